// File: rtl/sort_input_loader_pkg.sv
// Shared definitions for the sort input loader and the bitonic sorter.
// Also holds the demo batch loaded when SORT_LOADER_PRESET_EN is defined.
package sort_pkg;

  localparam int unsigned SORT_WIDTH = 8;
  localparam int unsigned SORT_N     = 16;

  typedef enum logic {
    FILL  = 1'b0,
    OFFER = 1'b1
  } loader_state_t;

  // Demo batch, entry 0 first.
  localparam int unsigned SORT_DEMO [16] = '{9, 1, 5, 2, 3, 4, 6, 7, 0, 8, 10, 12, 11, 13, 15, 14};

endpackage

// File: rtl/sort_input_loader_if.sv
// Batch handshake between the input loader (master) and the sorter (slave).
interface sort_input_loader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 16
);

  logic [N*WIDTH-1:0] data_out;
  logic               out_valid;
  logic               out_ready;

  modport master (output data_out, output out_valid, input out_ready);
  modport slave  (input data_out, input out_valid, output out_ready);

endinterface

// File: rtl/sort_input_loader_key_debouncer.sv
// Pushbutton conditioner: 2-FF synchroniser, level debounce, one-cycle press pulse.
// Reusable for any active-low key.
module key_debouncer #(
  parameter int unsigned DEB_CYCLES = 1048575
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      level       <= 1'b1;
      level_d     <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      level_d     <= level;
      press_pulse <= level_d & ~level;
      // Counts consecutive cycles of disagreement; any agreement restarts it.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sort_input_loader.sv
// Key-driven batch loader feeding the bitonic sorter over a valid/ready handshake.
// Define SORT_LOADER_PRESET_EN to reset into OFFER holding the demo batch.
module sort_input_loader
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH      = SORT_WIDTH,
  parameter int unsigned N          = SORT_N,
  parameter int unsigned DEB_CYCLES = 1048575
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_n,
  input  logic                 clr,
  input  logic [9:0]           sw,
  sort_input_loader_if.master  bus,
  output logic [$clog2(N):0]   count,
  output logic [9:0]           led
);

  localparam int unsigned CW = $clog2(N) + 1;

  loader_state_t  state;
  loader_state_t  state_n;
  logic [CW-1:0]  count_n;
  logic           out_valid_n;
  logic           wr_en;
  logic           press_pulse;
  logic [CW-2:0]  wr_idx;
  logic [WIDTH-1:0] buf_q [N];
  logic [5:0]     last_q;
  logic           sw_unused;

  assign sw_unused = ^sw;
  assign wr_idx    = count[CW-2:0];

  key_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .press_pulse (press_pulse)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef SORT_LOADER_PRESET_EN
      state         <= OFFER;
      count         <= CW'(N);
      bus.out_valid <= 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        buf_q[i] <= WIDTH'(SORT_DEMO[i % 16]);
      end
`else
      state         <= FILL;
      count         <= '0;
      bus.out_valid <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
`endif
      last_q <= '0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      bus.out_valid <= out_valid_n;
      if (wr_en) begin
        buf_q[wr_idx] <= sw[WIDTH-1:0];
        last_q        <= 6'(sw[WIDTH-1:0]);
      end
    end
  end

  // clr outranks both the press and the handshake; the N-th write is the last in FILL.
  always_comb begin
    state_n = state;
    count_n = count;
    wr_en   = 1'b0;
    if (clr) begin
      state_n = FILL;
      count_n = '0;
    end else begin
      case (state)
        FILL: begin
          if (press_pulse) begin
            wr_en   = 1'b1;
            count_n = count + 1'b1;
            if (count == CW'(N - 1)) state_n = OFFER;
          end
        end
        OFFER: begin
          if (bus.out_valid && bus.out_ready) begin
            state_n = FILL;
            count_n = '0;
          end
        end
        default: begin
          state_n = FILL;
          count_n = '0;
        end
      endcase
    end
    out_valid_n = (state_n == OFFER);
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign bus.data_out[g*WIDTH +: WIDTH] = buf_q[g];
  end

  assign led = {4'(count), last_q};

endmodule
